// File: rtl/idma_desc64_submit_arbiter.sv
// rtl/idma_desc64_submit_arbiter.sv - round-robin arbiter sharing the desc64 descriptor-address submission port
// Optional per-requester grant counters: define IDMA_DESC64_SUBMIT_ARB_PERF_CNT_EN.
module idma_desc64_submit_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
`ifdef IDMA_DESC64_SUBMIT_ARB_PERF_CNT_EN
  , parameter int unsigned CntWidth = 16
`endif
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [AddrWidth-1:0]          out_addr_o,
  output logic [IdWidth-1:0]            out_id_o,
`ifdef IDMA_DESC64_SUBMIT_ARB_PERF_CNT_EN
  input  logic                          cnt_clear_i,
  output logic [NumReq*CntWidth-1:0]    cnt_o,
`endif
  output logic                          busy_o
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   rr_q;
  logic [AddrWidth-1:0] addr_q;
  logic [IdWidth-1:0]   id_q;

  logic                 found;
  logic [IdWidth-1:0]   winner;
  logic [IdWidth:0]     cand;
  logic                 slot_free;
  logic                 grant;
  logic [IdWidth-1:0]   rr_next;

  // Search starting at rr_q and wrapping, so the first valid requester after the last winner gets it.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_q} + (IdWidth+1)'(k);
      if (cand >= (IdWidth+1)'(NumReq)) begin
        cand = cand - (IdWidth+1)'(NumReq);
      end
      if (!found && req_valid_i[IdWidth'(cand)]) begin
        found  = 1'b1;
        winner = IdWidth'(cand);
      end
    end
  end

  assign slot_free = (state_q == EMPTY) || out_ready_i;
  assign grant     = !rst_i && enable_i && slot_free && found;
  assign rr_next   = (winner == IdWidth'(NumReq - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (out_ready_i && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      addr_q <= '0;
      id_q   <= '0;
    end else if (grant) begin
      rr_q   <= rr_next;
      addr_q <= req_addr_i[winner*AddrWidth +: AddrWidth];
      id_q   <= winner;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign busy_o      = (state_q == FULL);
  assign out_addr_o  = addr_q;
  assign out_id_o    = id_q;

`ifdef IDMA_DESC64_SUBMIT_ARB_PERF_CNT_EN
  logic [NumReq-1:0][CntWidth-1:0] cnt_q;

  // Clear takes priority over a same-cycle grant; counters stick at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_clear_i) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (req_valid_i[i] && req_ready_o[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_idma_desc64_submit_arbiter.sv
// tb/tb_idma_desc64_submit_arbiter.sv - self-checking bench for idma_desc64_submit_arbiter
module tb_idma_desc64_submit_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int IW = 2;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    rv;
  logic [N-1:0]    rr_o;
  logic [N*AW-1:0] ra;
  logic            ov;
  logic            ordy;
  logic [AW-1:0]   oa;
  logic [IW-1:0]   oid;
  logic            busy;
`ifdef IDMA_DESC64_SUBMIT_ARB_PERF_CNT_EN
  logic            clr;
  logic [N*CW-1:0] cnt;
`endif

  always #5 clk = ~clk;

  idma_desc64_submit_arbiter #(.NumReq(N), .AddrWidth(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (en),
    .req_valid_i (rv),
    .req_ready_o (rr_o),
    .req_addr_i  (ra),
    .out_valid_o (ov),
    .out_ready_i (ordy),
    .out_addr_o  (oa),
    .out_id_o    (oid),
`ifdef IDMA_DESC64_SUBMIT_ARB_PERF_CNT_EN
    .cnt_clear_i (clr),
    .cnt_o       (cnt),
`endif
    .busy_o      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: one held slot, a round-robin start index, and per-requester wait tallies.
  bit            m_full;
  logic [AW-1:0] m_addr;
  int            m_id;
  int            m_rr;
  int            wait_cnt [N];

  task automatic model_reset();
    m_full = 0;
    m_addr = '0;
    m_id   = 0;
    m_rr   = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_fixed_addrs();
    for (int i = 0; i < N; i++) ra[i*AW +: AW] = AW'(32'hA0 + 32'h10 * i);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic [N-1:0] v, input logic e, input logic r, output logic [N-1:0] seen);
    int w;
    logic [N-1:0] expr;
    rv = v; en = e; ordy = r;
    #1;
    chk("out_valid", ov, m_full);
    chk("busy", busy, m_full);
    if (m_full) begin
      chk("out_addr", oa, m_addr);
      chk("out_id", oid, m_id);
    end
    w = pick(v);
    expr = '0;
    if (e && (!m_full || r) && w >= 0) expr[w] = 1'b1;
    chk("req_ready", rr_o, expr);
    seen = rr_o;
    for (int i = 0; i < N; i++) begin
      if (!v[i] || rr_o[i]) begin
        wait_cnt[i] = 0;
      end else if (rr_o != '0) begin
        wait_cnt[i]++;
        chk("starve_bound", wait_cnt[i] <= N - 1, 1);
      end
    end
    @(posedge clk);
    if (expr != '0) begin
      m_full = 1;
      m_addr = ra[w*AW +: AW];
      m_id   = w;
      m_rr   = (w + 1) % N;
    end else if (m_full && r) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rv = '1; en = 1'b1; ordy = 1'b1;
    #1;
    chk("rst_out_valid", ov, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", rr_o, 0);
    chk("rst_out_addr", oa, 0);
    chk("rst_out_id", oid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rv = '0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         e;
    logic         r;
    logic [N-1:0] rdy;
    logic         full;
    int           id;
  } vec_t;

  vec_t tbl [10];
  logic [N-1:0] seen;

  initial begin
    tbl[0] = '{3'b001, 1'b1, 1'b1, 3'b001, 1'b1, 0};
    tbl[1] = '{3'b011, 1'b1, 1'b1, 3'b010, 1'b1, 1};
    tbl[2] = '{3'b011, 1'b1, 1'b1, 3'b001, 1'b1, 0};
    tbl[3] = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 0};
    tbl[4] = '{3'b111, 1'b0, 1'b1, 3'b000, 1'b0, 0};
    tbl[5] = '{3'b111, 1'b1, 1'b0, 3'b010, 1'b1, 1};
    tbl[6] = '{3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 2};
    tbl[7] = '{3'b110, 1'b1, 1'b1, 3'b010, 1'b1, 1};
    tbl[8] = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 0};
    tbl[9] = '{3'b100, 1'b1, 1'b0, 3'b100, 1'b1, 2};

    rst = 1'b0; en = 1'b0; rv = '0; ordy = 1'b0; ra = '0;
`ifdef IDMA_DESC64_SUBMIT_ARB_PERF_CNT_EN
    clr = 1'b0;
`endif
    model_reset();

    // Single requester, one-cycle latency
    do_reset();
    set_fixed_addrs();
    ra[0 +: AW] = 32'h1000;
    cycle(3'b001, 1'b1, 1'b1, seen);
    chk("single_ready", seen, 3'b001);
    chk("single_valid", ov, 1);
    chk("single_addr", oa, 32'h1000);
    chk("single_id", oid, 0);

    // Table of vectors from reset
    do_reset();
    set_fixed_addrs();
    for (int t = 0; t < 10; t++) begin
      cycle(tbl[t].v, tbl[t].e, tbl[t].r, seen);
      chk($sformatf("tbl%0d_ready", t), seen, tbl[t].rdy);
      chk($sformatf("tbl%0d_valid", t), ov, tbl[t].full);
      if (tbl[t].full) begin
        chk($sformatf("tbl%0d_id", t), oid, tbl[t].id);
        chk($sformatf("tbl%0d_addr", t), oa, 32'hA0 + 32'h10 * tbl[t].id);
      end
    end

    // Two-way contention alternates every cycle
    do_reset();
    set_fixed_addrs();
    for (int k = 0; k < 4; k++) begin
      cycle(3'b011, 1'b1, 1'b1, seen);
      chk("rr_id", oid, k % 2);
      chk("rr_addr", oa, (k % 2) ? 32'hB0 : 32'hA0);
    end

    // Backpressure holds entry, then same-cycle refill on ready
    do_reset();
    ra[0 +: AW] = 32'h2000;
    cycle(3'b001, 1'b1, 1'b1, seen);
    for (int k = 0; k < 5; k++) begin
      cycle(3'b011, 1'b1, 1'b0, seen);
      chk("bp_ready", seen, 0);
      chk("bp_addr", oa, 32'h2000);
    end
    cycle(3'b011, 1'b1, 1'b1, seen);
    chk("bp_refill", seen, 3'b010);

    // enable low drains without refill
    cycle(3'b010, 1'b0, 1'b1, seen);
    chk("en_low_ready", seen, 0);
    chk("en_low_drained", ov, 0);
    cycle(3'b010, 1'b0, 1'b1, seen);
    chk("en_low_hold", seen, 0);
    cycle(3'b010, 1'b1, 1'b0, seen);
    chk("en_high_grant", seen, 3'b010);
    chk("en_high_id", oid, 1);

    // Asynchronous reset while FULL
    chk("pre_rst_valid", ov, 1);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", ov, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(3'b111, 1'b1, 1'b1, seen);
    chk("post_rst_tie", seen, 3'b001);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) ra[i*AW +: AW] = $urandom;
      cycle(N'($urandom), ($urandom % 8) != 0, ($urandom % 3) != 0, seen);
    end

`ifdef IDMA_DESC64_SUBMIT_ARB_PERF_CNT_EN
    do_reset();
    for (int k = 0; k < 3; k++) cycle(3'b010, 1'b1, 1'b1, seen);
    chk("cnt1_three", cnt[1*CW +: CW], 3);
    chk("cnt0_zero", cnt[0 +: CW], 0);
    clr = 1'b1;
    cycle(3'b010, 1'b1, 1'b1, seen);
    clr = 1'b0;
    chk("cnt_clear_wins", cnt[1*CW +: CW], 0);
    rv = 3'b001; en = 1'b1; ordy = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk("cnt_full", cnt[0 +: CW], 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    chk("cnt_saturate", cnt[0 +: CW], 16'hFFFF);
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
